// File: rtl/fwft_unpacker_pkg.sv
// Shared definitions for the FWFT word unpacker and its future packer mirror.
// Holds the state encoding and the width-geometry check.
package fwft_unpacker_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } fwft_state_t;

   // A word must split into a whole number of beats, at least two of them.
   function automatic bit fwft_geometry_ok(input int in_w, input int out_w, input int ratio);
      return (ratio >= 2) && (in_w == out_w * ratio);
   endfunction

endpackage

// File: rtl/fwft_unpacker.sv
// Pops full-width words from an FWFT FIFO head and emits them as RATIO
// narrower valid/ready beats, with a last-beat marker and no bubble between words.
module fwft_unpacker
   import fwft_unpacker_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
   parameter bit MSB_FIRST = 1'b0,
   parameter int CW        = $clog2(RATIO)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_read,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   if (!fwft_geometry_ok(IN_WIDTH, OUT_WIDTH, RATIO)) begin : g_bad_geometry
      $error("fwft_unpacker: IN_WIDTH must equal OUT_WIDTH * RATIO with RATIO >= 2");
   end

   localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

   fwft_state_t         state;
   logic [CW-1:0]       beat_cnt;
   logic [IN_WIDTH-1:0] sreg;
   logic [IN_WIDTH-1:0] sreg_next_beat;
   logic                accept;
   logic                end_word;
   logic                load;

   assign out_valid = (state == ST_SHIFT);
   assign busy      = (state == ST_SHIFT);
   assign accept    = out_valid & out_ready;
   assign end_word  = accept & (beat_cnt == LAST_BEAT);
   assign out_last  = out_valid & (beat_cnt == LAST_BEAT);

   // Reset gates the pop so the FIFO pointer never moves while we are held.
   assign load      = rst & ~fifo_empty & ((state == ST_IDLE) | end_word);
   assign fifo_read = load;

   if (MSB_FIRST) begin : g_msb_first
      assign out_data       = sreg[IN_WIDTH-1 -: OUT_WIDTH];
      assign sreg_next_beat = {sreg[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
   end else begin : g_lsb_first
      assign out_data       = sreg[OUT_WIDTH-1:0];
      assign sreg_next_beat = {{OUT_WIDTH{1'b0}}, sreg[IN_WIDTH-1:OUT_WIDTH]};
   end

   // Load takes priority over end_word so a waiting word reloads back-to-back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         sreg     <= '0;
      end else if (load) begin
         state    <= ST_SHIFT;
         beat_cnt <= '0;
         sreg     <= fifo_dout;
      end else if (end_word) begin
         state    <= ST_IDLE;
      end else if (accept) begin
         beat_cnt <= beat_cnt + CW'(1);
         sreg     <= sreg_next_beat;
      end
   end

endmodule

// File: tb/tb_fwft_unpacker.sv
// Directed bench for fwft_unpacker: LSB-first and MSB-first instances share
// one behavioural FWFT FIFO; expected beats are hand-computed per scenario.
module tb_fwft_unpacker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_read, fifo_read_m;
   logic [7:0]  out_data, out_data_m;
   logic        out_valid, out_valid_m;
   logic        out_last, out_last_m;
   logic        busy, busy_m;

   logic [31:0] mem [0:15];
   int          wr = 0;
   int          rd = 0;
   int          reads = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (wr == rd);
   assign fifo_dout  = mem[rd % 16];

   always @(posedge clk) begin
      if (fifo_read) begin
         rd    <= rd + 1;
         reads <= reads + 1;
      end
   end

   fwft_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_read(fifo_read), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy));

   fwft_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_read(fifo_read_m), .out_data(out_data_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m));

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr % 16] = w;
      wr = wr + 1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      vectors++;
      if ({out_valid, out_last, busy, fifo_read, out_data} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_lsb: got v%b l%b b%b r%b d%h want all 0",
                  out_valid, out_last, busy, fifo_read, out_data);
      end
      vectors++;
      if ({out_valid_m, out_last_m, busy_m, out_data_m} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_msb: got v%b l%b b%b d%h want all 0",
                  out_valid_m, out_last_m, busy_m, out_data_m);
      end
      push(32'hAABBCCDD);
      vectors++;
      if (fifo_read !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_read_gate: got %b want 0", fifo_read);
      end
      rst = 1'b1;
      #1;
   endtask

   // Entered just after reset release with 0xAABBCCDD at the FIFO head.
   task automatic test_one_word();
      logic [7:0] exp [4];
      int r0;
      exp = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      r0 = reads;
      vectors++;
      if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL one_word_latency: got read %b valid %b want read 1 valid 0",
                  fifo_read, out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3) || fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL one_word_beat%0d: got v%b d%h l%b r%b want v1 d%h l%0d r0",
                     i, out_valid, out_data, out_last, fifo_read, exp[i], (i == 3));
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || reads - r0 !== 1) begin
         miscompares++;
         $display("FAIL one_word_idle: got v%b b%b pops %0d want v0 b0 pops 1",
                  out_valid, busy, reads - r0);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] exp [4];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      push(32'hAABBCCDD);
      vectors++;
      if (fifo_read_m !== 1'b1) begin
         miscompares++;
         $display("FAIL msb_read: got %b want 1", fifo_read_m);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid_m !== 1'b1 || out_data_m !== exp[i] || out_last_m !== (i == 3)) begin
            miscompares++;
            $display("FAIL msb_beat%0d: got v%b d%h l%b want v1 d%h l%0d",
                     i, out_valid_m, out_data_m, out_last_m, exp[i], (i == 3));
         end
      end
      tick();
      vectors++;
      if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
         miscompares++;
         $display("FAIL msb_idle: got v%b b%b want v0 b0", out_valid_m, busy_m);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [8];
      exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      push(32'h11223344);
      push(32'h55667788);
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3 || i == 7) ||
             fifo_read !== (i == 3)) begin
            miscompares++;
            $display("FAIL b2b_beat%0d: got v%b d%h l%b r%b want v1 d%h l%0d r%0d",
                     i, out_valid, out_data, out_last, fifo_read, exp[i],
                     (i == 3 || i == 7), (i == 3));
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: got v%b b%b want v0 b0", out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [4];
      exp = '{8'h44, 8'h33, 8'h22, 8'h11};
      push(32'hAABBCCDD);
      tick();
      vectors++;
      if (out_data !== 8'hDD || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_beat0: got v%b d%h want v1 dDD", out_valid, out_data);
      end
      push(32'h11223344);
      tick();
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== 8'hCC || out_last !== 1'b0 || fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got v%b d%h l%b r%b want v1 dCC l0 r0",
                     i, out_valid, out_data, out_last, fifo_read);
         end
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hBB || out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_resume_bb: got v%b d%h l%b want v1 dBB l0", out_valid, out_data, out_last);
      end
      tick();
      vectors++;
      if (out_data !== 8'hAA || out_last !== 1'b1 || fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_resume_aa: got d%h l%b r%b want dAA l1 r1", out_data, out_last, fifo_read);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
            miscompares++;
            $display("FAIL bp_next%0d: got v%b d%h l%b want v1 d%h l%0d",
                     i, out_valid, out_data, out_last, exp[i], (i == 3));
         end
      end
      tick();
   endtask

   task automatic test_empty_boundary();
      logic [7:0] exp [4];
      logic [7:0] exp2 [4];
      exp  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      exp2 = '{8'h78, 8'h56, 8'h34, 8'h12};
      push(32'hAABBCCDD);
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_data !== exp[i] || out_last !== (i == 3) || fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_beat%0d: got d%h l%b r%b want d%h l%0d r0",
                     i, out_data, out_last, fifo_read, exp[i], (i == 3));
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_read !== 1'b0 || fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_idle%0d: got v%b b%b r%b e%b want v0 b0 r0 e1",
                     i, out_valid, busy, fifo_read, fifo_empty);
         end
      end
      push(32'h12345678);
      vectors++;
      if (fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_repush_read: got %b want 1", fifo_read);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp2[i] || out_last !== (i == 3)) begin
            miscompares++;
            $display("FAIL empty_repush_beat%0d: got v%b d%h l%b want v1 d%h l%0d",
                     i, out_valid, out_data, out_last, exp2[i], (i == 3));
         end
      end
      tick();
   endtask

   task automatic test_async_reset();
      logic [7:0] exp [4];
      exp = '{8'h66, 8'h77, 8'h88, 8'h99};
      push(32'hAABBCCDD);
      push(32'h99887766);
      tick();
      tick();
      vectors++;
      if (out_data !== 8'hCC || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL arst_pre: got v%b d%h want v1 dCC", out_valid, out_data);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || fifo_read !== 1'b0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL arst_drop: got v%b l%b b%b r%b d%h want all 0",
                  out_valid, out_last, busy, fifo_read, out_data);
      end
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (fifo_read !== 1'b1 || fifo_dout !== 32'h99887766) begin
         miscompares++;
         $display("FAIL arst_release: got r%b head %h want r1 head 99887766", fifo_read, fifo_dout);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3)) begin
            miscompares++;
            $display("FAIL arst_beat%0d: got v%b d%h l%b want v1 d%h l%0d",
                     i, out_valid, out_data, out_last, exp[i], (i == 3));
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL arst_idle: got v%b b%b want v0 b0", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_one_word();
      test_msb_first();
      test_back_to_back();
      test_backpressure();
      test_empty_boundary();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
